video_timing_gen: RTL

- Parametrised successor to the fixed 320x240 sync generator. Produces H/V/composite sync, blanking and active-area flags, line/frame strobes and scan counters from one system clock.
- Uses a pixel clock-enable instead of a derived clock.
- Sits between the system clock domain and the RGB/SCART/VGA DAC. Downstream pixel logic consumes H_COUNTER, V_COUNTER, ACTIVE and PIX_CE.

---
 rtl/video_timing_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. A clock-enable divider produces one
//   PIX_CE pulse every PIX_DIV CLOCK cycles. Horizontal and vertical scan
//   counters advance on that enable. Sync, blanking and active flags are
//   decoded from the counters and registered.
//
//   Line layout (H_COUNTER order): front porch, sync, back porch, active.
//   The frame uses the same order with the V_ parameters.
//
// Ports
//   CLOCK        in   system clock (the only clock)
//   RESET        in   synchronous, active-high reset
//   PIX_CE       out  one-CLOCK pixel enable, every PIX_DIV cycles
//   PIXEL_CLOCK  out  pixel clock for the DAC, high for div_cnt >= PIX_DIV/2
//   H_SYNC       out  horizontal sync, polarity H_SYNC_POL
//   V_SYNC       out  vertical sync, polarity V_SYNC_POL
//   C_SYNC       out  composite sync (H xor V), polarity C_SYNC_POL
//   VGA_BLANK    out  active-low blank (equals ACTIVE)
//   ACTIVE       out  high inside the visible area
//   LINE_START   out  one-CLOCK strobe after each line wrap
//   FRAME_START  out  one-CLOCK strobe after each frame wrap
//   H_COUNTER    out  pixel position 0..H_PERIOD-1
//   V_COUNTER    out  line position 0..V_PERIOD-1
//
// Optional build macro
//   VIDEO_TIMING_FRAME_CNT_EN adds FRAME_COUNT[15:0] and FIELD
//   (FRAME_COUNT[0]). FRAME_COUNT increments on every frame wrap.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int CNT_W      = 10,
  parameter int PIX_DIV    = 16,
  parameter int H_PIXELS   = 320,
  parameter int H_FP       = 4,
  parameter int H_SYNC_LEN = 48,
  parameter int H_BP       = 28,
  parameter int V_PIXELS   = 240,
  parameter int V_FP       = 1,
  parameter int V_SYNC_LEN = 15,
  parameter int V_BP       = 4,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int C_SYNC_POL = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  output logic             PIX_CE,
  output logic             PIXEL_CLOCK,
  output logic             H_SYNC,
  output logic             V_SYNC,
  output logic             C_SYNC,
  output logic             VGA_BLANK,
  output logic             ACTIVE,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic [CNT_W-1:0] H_COUNTER,
  output logic [CNT_W-1:0] V_COUNTER
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      FRAME_COUNT,
  output logic             FIELD
`endif
);

  localparam int H_PERIOD = H_FP + H_SYNC_LEN + H_BP + H_PIXELS;
  localparam int V_PERIOD = V_FP + V_SYNC_LEN + V_BP + V_PIXELS;

  // A 1-bit divider is kept for PIX_DIV=1; it simply stays at 0.
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_PERIOD - 1);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_FP + H_SYNC_LEN);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_FP + H_SYNC_LEN + H_BP);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_FP + V_SYNC_LEN);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_FP + V_SYNC_LEN + V_BP);

  localparam logic H_POL = (H_SYNC_POL != 0);
  localparam logic V_POL = (V_SYNC_POL != 0);
  localparam logic C_POL = (C_SYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [CNT_W-1:0] h_cnt_reg;
  logic [CNT_W-1:0] v_cnt_reg;
  logic [CNT_W-1:0] h_cnt_next;
  logic [CNT_W-1:0] v_cnt_next;
  logic             pix_ce;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_act_next;
  logic             vs_act_next;
  logic             active_next;
  logic             h_sync_reg;
  logic             v_sync_reg;
  logic             c_sync_reg;
  logic             active_reg;
  logic             line_start_reg;
  logic             frame_start_reg;

  // Pixel enable is decoded straight from the divider register, so the
  // first pulse after reset appears PIX_DIV-1 cycles after release.
  assign pix_ce = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Next-state counters and decode. The sync/active flags are decoded from
  // the next counter values and registered alongside the counters, which
  // keeps them cycle-aligned with H_COUNTER/V_COUNTER and glitch-free.
  always_comb begin
    h_wrap     = pix_ce && (h_cnt_reg == H_LAST);
    v_wrap     = h_wrap && (v_cnt_reg == V_LAST);
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_ce) begin
      h_cnt_next = (h_cnt_reg == H_LAST) ? '0 : h_cnt_reg + CNT_W'(1);
    end
    // V only moves on an H wrap, so both wrap on the same edge.
    if (h_wrap) begin
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CNT_W'(1);
    end
    hs_act_next = (h_cnt_next >= H_SYNC_BEG) && (h_cnt_next < H_SYNC_END);
    vs_act_next = (v_cnt_next >= V_SYNC_BEG) && (v_cnt_next < V_SYNC_END);
    active_next = (h_cnt_next >= H_ACT_BEG) && (v_cnt_next >= V_ACT_BEG);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      h_sync_reg      <= ~H_POL;
      v_sync_reg      <= ~V_POL;
      c_sync_reg      <= ~C_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      h_sync_reg      <= hs_act_next ? H_POL : ~H_POL;
      v_sync_reg      <= vs_act_next ? V_POL : ~V_POL;
      // XOR yields inverted (serrated) H pulses during vertical sync.
      c_sync_reg      <= (hs_act_next ^ vs_act_next) ? C_POL : ~C_POL;
      active_reg      <= active_next;
      line_start_reg  <= h_wrap;
      frame_start_reg <= v_wrap;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Increments on the same edge that raises FRAME_START; wraps modulo 2^16.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      frame_cnt_reg <= '0;
    end else if (v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign FRAME_COUNT = frame_cnt_reg;
  assign FIELD       = frame_cnt_reg[0];
`else
  // Frame counter not built: no FRAME_COUNT/FIELD ports.
`endif

  assign PIX_CE      = pix_ce;
  assign PIXEL_CLOCK = (div_cnt_reg >= DIV_HALF);
  assign H_SYNC      = h_sync_reg;
  assign V_SYNC      = v_sync_reg;
  assign C_SYNC      = c_sync_reg;
  assign ACTIVE      = active_reg;
  assign VGA_BLANK   = active_reg;
  assign LINE_START  = line_start_reg;
  assign FRAME_START = frame_start_reg;
  assign H_COUNTER   = h_cnt_reg;
  assign V_COUNTER   = v_cnt_reg;

endmodule
